// File: rtl/string_feeder_if.sv
// Purpose : bundles the load, stream-control and matcher-facing signals of string_feeder.
// Latency : n/a (signal bundle only).
// Backpressure: pause travels toward the feeder; the feeder drives all status/matcher outputs.
//
// Ports:
//   wr_en/wr_data : load one byte into the buffer (IDLE only)
//   start         : begin streaming the buffered bytes
//   pause         : matcher-side stall
//   en/initialize/string_dat : matcher byte strobe, step strobe and byte
//   level/full/busy/done/overflow : buffer and stream status
interface string_feeder_if #(
    parameter int AW = 5
);
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          start;
    logic          pause;
    logic          en;
    logic          initialize;
    logic [7:0]    string_dat;
    logic [AW:0]   level;
    logic          full;
    logic          busy;
    logic          done;
    logic          overflow;

    // master: the block that loads bytes and controls the stream
    modport master (
        output wr_en, wr_data, start, pause,
        input  en, initialize, string_dat, level, full, busy, done, overflow
    );

    // slave: the feeder itself
    modport slave (
        input  wr_en, wr_data, start, pause,
        output en, initialize, string_dat, level, full, busy, done, overflow
    );
endinterface

// File: rtl/string_feeder.sv
// Purpose : buffers up to DEPTH bytes, then streams them to a matcher as INIT, FEED, GAP.., FINISH.
// Latency : first en cycle is the second cycle after the start edge; N bytes take 2N+1 busy cycles.
// Backpressure: pause sampled at an edge freezes the state due in the following cycle (en/initialize low).
//
// Ports:
//   clk, rst : single clock, asynchronous active-high reset
//   sf       : string_feeder_if.slave (load/start/pause in; matcher strobes and status out)
// Every output is a flop; all next values are computed from state plus inputs at the clock edge.
module string_feeder #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    string_feeder_if.slave  sf
);

    generate
        if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 || (1 << AW) != DEPTH) begin : g_param_check
            $error("string_feeder: DEPTH must be a power of two in 2..256 and AW = log2(DEPTH)");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        FEED,
        GAP,
        FINISH
    } state_t;

    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] IDX_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [7:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic        held_q, held_d;      // current cycle's state is frozen by pause
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0] n_q, n_d;
    logic [AW:0] level_q, level_d;
    logic [AW:0] lvl_tmp;
    logic        ovf_q, ovf_d;
    logic        en_q, en_d;
    logic        init_q, init_d;
    logic [7:0]  str_q, str_d;
    logic        full_q, full_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        we;

    // Bytes are only written while idle and the count is only cleared on FINISH,
    // so the fill level doubles as the write pointer.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[level_q[AW-1:0]] <= sf.wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        lvl_tmp = level_q;

        case (state_q)
            IDLE: begin
                // a write in the same cycle as start lands first and is counted in N
                if (sf.wr_en) begin
                    if (!full_q) begin
                        we      = 1'b1;
                        lvl_tmp = level_q + LVL_ONE;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                level_d = lvl_tmp;
                if (sf.start && lvl_tmp != '0) begin
                    ovf_d   = 1'b0;
                    n_d     = lvl_tmp;
                    idx_d   = '0;
                    state_d = INIT;
                end
            end
            INIT: begin
                if (!held_q) state_d = FEED;
            end
            FEED: begin
                if (!held_q) begin
                    if ({1'b0, idx_q} == n_q - LVL_ONE) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (!held_q) state_d = FEED;
            end
            FINISH: begin
                level_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // pause cannot hold IDLE or FINISH
        held_d = sf.pause && (state_d == INIT || state_d == FEED || state_d == GAP);
        en_d   = (state_d == FEED) && !held_d;
        init_d = (state_d == INIT || state_d == GAP) && !held_d;
        done_d = (state_d == FINISH);
        busy_d = (state_d != IDLE);
        full_d = (level_d == DEPTH_L);
        str_d  = en_d ? mem[idx_d] : str_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            held_q  <= 1'b0;
            idx_q   <= '0;
            n_q     <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            en_q    <= 1'b0;
            init_q  <= 1'b0;
            str_q   <= 8'h00;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            en_q    <= en_d;
            init_q  <= init_d;
            str_q   <= str_d;
            full_q  <= full_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sf.en         = en_q;
    assign sf.initialize = init_q;
    assign sf.string_dat = str_q;
    assign sf.level      = level_q;
    assign sf.full       = full_q;
    assign sf.busy       = busy_q;
    assign sf.done       = done_q;
    assign sf.overflow   = ovf_q;

endmodule

// File: tb/tb_string_feeder.sv
module tb_string_feeder;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    string_feeder_if #(.AW(AW)) sf_bus ();

    string_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .sf  (sf_bus)
    );

    int errors = 0;
    int checks = 0;

    // reference model: the buffered bytes in load order, overflow flag, last byte shown
    logic [7:0] model_q[$];
    logic       model_ovf;
    logic [7:0] last_str;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_en"},    32'(sf_bus.en), 0);
        check({pfx, "_init"},  32'(sf_bus.initialize), 0);
        check({pfx, "_str"},   32'(sf_bus.string_dat), 0);
        check({pfx, "_level"}, 32'(sf_bus.level), 0);
        check({pfx, "_full"},  32'(sf_bus.full), 0);
        check({pfx, "_busy"},  32'(sf_bus.busy), 0);
        check({pfx, "_done"},  32'(sf_bus.done), 0);
        check({pfx, "_ovf"},   32'(sf_bus.overflow), 0);
    endtask

    task automatic model_clear();
        model_q.delete();
        model_ovf = 1'b0;
        last_str  = 8'h00;
    endtask

    task automatic write_byte(input logic [7:0] b);
        sf_bus.wr_en   = 1'b1;
        sf_bus.wr_data = b;
        tick();
        sf_bus.wr_en   = 1'b0;
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else model_ovf = 1'b1;
        check("wr_level", 32'(sf_bus.level), model_q.size());
        check("wr_full",  32'(sf_bus.full), (model_q.size() == DEPTH) ? 1 : 0);
        check("wr_ovf",   32'(sf_bus.overflow), 32'(model_ovf));
        check("wr_busy",  32'(sf_bus.busy), 0);
    endtask

    task automatic start_empty();
        sf_bus.start = 1'b1;
        tick();
        sf_bus.start = 1'b0;
        check("empty_busy", 32'(sf_bus.busy), 0);
        check("empty_en",   32'(sf_bus.en), 0);
        check("empty_done", 32'(sf_bus.done), 0);
        tick();
        check("empty_busy2", 32'(sf_bus.busy), 0);
        check("empty_done2", 32'(sf_bus.done), 0);
    endtask

    // Expected cycle list of a stream: event 0 = INIT, odd = FEED byte (e-1)/2,
    // even 0<e<2N = GAP, 2N = FINISH. Each pause sample taken at an edge that would
    // move into INIT/FEED/GAP adds one frozen cycle in front of that event.
    // mode: 0 no pause, 1 random pause, 2 four pauses in front of event 3 (second FEED).
    task automatic run_stream(input int mode, input bit add_write, input logic [7:0] add_byte,
                              input int abort_at, output int busy_cnt);
        logic [7:0] exp_b[$];
        int  n, e, e_next, pauses, done_cnt;
        bit  paused, paused_next, p, reached;
        logic exp_en, exp_init;

        if (add_write) begin
            sf_bus.wr_en   = 1'b1;
            sf_bus.wr_data = add_byte;
            if (model_q.size() < DEPTH) model_q.push_back(add_byte);
        end
        exp_b = model_q;
        n = exp_b.size();
        sf_bus.start = 1'b1;
        sf_bus.pause = 1'b0;
        tick();
        sf_bus.start = 1'b0;
        sf_bus.wr_en = 1'b0;
        model_ovf = 1'b0;

        e = 0; paused = 1'b0; pauses = 0; busy_cnt = 0; done_cnt = 0; reached = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            busy_cnt += int'(sf_bus.busy);
            done_cnt += int'(sf_bus.done);
            exp_en   = !paused && (e % 2 == 1);
            exp_init = !paused && (e % 2 == 0) && (e < 2 * n);
            if (exp_en) last_str = exp_b[(e - 1) / 2];
            check("st_en",    32'(sf_bus.en), 32'(exp_en));
            check("st_init",  32'(sf_bus.initialize), 32'(exp_init));
            check("st_str",   32'(sf_bus.string_dat), 32'(last_str));
            check("st_busy",  32'(sf_bus.busy), 1);
            check("st_done",  32'(sf_bus.done), (e == 2 * n) ? 1 : 0);
            check("st_level", 32'(sf_bus.level), n);
            check("st_ovf",   32'(sf_bus.overflow), 0);
            if (e == 2 * n) begin
                reached = 1'b1;
                break;
            end
            if (abort_at == e && !paused) begin
                rst = 1'b1;
                #1;
                check_zero("abort");
                @(negedge clk);
                rst = 1'b0;
                sf_bus.wr_en = 1'b0;
                sf_bus.pause = 1'b0;
                model_clear();
                return;
            end
            e_next = paused ? e : e + 1;
            p = 1'b0;
            if (mode == 1) p = ($urandom_range(0, 3) == 0);
            if (mode == 2) p = (e_next == 3) && (pauses < 4);
            if (cyc > 3000) p = 1'b0;
            paused_next = p && (e_next != 2 * n);
            pauses += int'(paused_next);
            sf_bus.pause   = p;
            sf_bus.wr_en   = ($urandom_range(0, 1) == 1);
            sf_bus.wr_data = 8'($urandom);
            tick();
            e = e_next;
            paused = paused_next;
        end
        check("st_reached_finish", 32'(reached), 1);
        sf_bus.pause = 1'b0;
        sf_bus.wr_en = 1'b0;
        tick();
        model_q.delete();
        check("post_busy",  32'(sf_bus.busy), 0);
        check("post_done",  32'(sf_bus.done), 0);
        check("post_level", 32'(sf_bus.level), 0);
        check("post_full",  32'(sf_bus.full), 0);
        check("post_en",    32'(sf_bus.en), 0);
        check("post_init",  32'(sf_bus.initialize), 0);
        check("post_str",   32'(sf_bus.string_dat), 32'(last_str));
        check("busy_cycles", busy_cnt, 2 * n + 1 + pauses);
        check("done_pulses", done_cnt, 1);
    endtask

    initial begin
        int bc;
        int nb;
        sf_bus.wr_en   = 1'b0;
        sf_bus.wr_data = 8'h00;
        sf_bus.start   = 1'b0;
        sf_bus.pause   = 1'b0;
        model_clear();

        #1 rst = 1'b1;
        #3;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // three-byte stream
        write_byte(8'h61);
        write_byte(8'h62);
        write_byte(8'h63);
        run_stream(0, 1'b0, 8'h00, -1, bc);
        check("abc_busy7", bc, 7);

        // start with an empty buffer
        start_empty();

        // fill to capacity plus one rejected write
        for (int i = 0; i < DEPTH; i++) write_byte(8'(i));
        write_byte(8'h20);
        check("full_flag",  32'(sf_bus.full), 1);
        check("full_ovf",   32'(sf_bus.overflow), 1);
        check("full_level", 32'(sf_bus.level), DEPTH);
        run_stream(0, 1'b0, 8'h00, -1, bc);
        check("full_busy", bc, 2 * DEPTH + 1);

        // four-cycle pause in front of the second byte
        write_byte(8'h61);
        write_byte(8'h62);
        write_byte(8'h63);
        run_stream(2, 1'b0, 8'h00, -1, bc);
        check("pause_busy11", bc, 11);

        // start and write in the same cycle with two bytes already held
        write_byte(8'h11);
        write_byte(8'h22);
        run_stream(1, 1'b1, 8'h7a, -1, bc);

        // reset during the first GAP of a five-byte stream, then a one-byte stream
        for (int i = 0; i < 5; i++) write_byte(8'hA0 + 8'(i));
        run_stream(0, 1'b0, 8'h00, 2, bc);
        write_byte(8'h5c);
        run_stream(0, 1'b0, 8'h00, -1, bc);
        check("one_busy3", bc, 3);

        // randomized loads (sometimes overfilled), pauses and ignored writes
        for (int it = 0; it < 8; it++) begin
            nb = $urandom_range(1, DEPTH + 2);
            for (int i = 0; i < nb; i++) write_byte(8'($urandom));
            run_stream(1, ($urandom_range(0, 1) == 1), 8'($urandom), -1, bc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/string_feeder.md
STRING_FEEDER -- requirements
Module: string_feeder

Interface
REQ-001 Parameter DEPTH, default 32, is the byte buffer depth; the block SHALL require DEPTH to be a power of two, 2..256.
REQ-002 Parameter AW, default 5, is the buffer address width; the block SHALL require AW = log2(DEPTH).
REQ-003 CLK  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 RST  in  1  reset, asynchronous and active-high.
REQ-005 WR_EN  in  1  write strobe for loading one byte into the buffer.
REQ-006 WR_DATA  in  8  byte to load.
REQ-007 START  in  1  request to stream the buffered bytes to the matcher.
REQ-008 PAUSE  in  1  stall from the matcher side.
REQ-009 EN  out  1  matcher enable; SHALL be high only in cycles that present a valid byte.
REQ-010 INITIALIZE  out  1  matcher step/initialize strobe.
REQ-011 STRING  out  8  byte presented to the matcher.
REQ-012 LEVEL  out  AW+1  number of bytes held in the buffer, 0..DEPTH.
REQ-013 FULL  out  1  high when LEVEL == DEPTH.
REQ-014 BUSY  out  1  high in every state except IDLE.
REQ-015 DONE  out  1  one-cycle pulse marking the end of a stream.
REQ-016 OVERFLOW  out  1  sticky error flag for a rejected write.

Function
REQ-017 The block SHALL register all outputs; there SHALL be no combinational path from any input to any output.
REQ-018 The FSM SHALL have states IDLE, INIT, FEED, GAP and FINISH.
REQ-019 In IDLE, a WR_EN with FULL=0 SHALL write WR_DATA at the write pointer and increment LEVEL.
REQ-020 In IDLE, a WR_EN with FULL=1 SHALL discard the byte and set OVERFLOW.
REQ-021 In any state other than IDLE, WR_EN SHALL be ignored and SHALL NOT set OVERFLOW.
REQ-022 In IDLE, START with LEVEL>0 SHALL clear OVERFLOW, latch N=LEVEL, set the read index to 0 and enter INIT.
REQ-023 In IDLE, START with LEVEL==0 SHALL be ignored, with no state change and no DONE.
REQ-024 If START and WR_EN are high in the same IDLE cycle, the write SHALL take effect first and N SHALL include the new byte.
REQ-025 INIT SHALL last 1 cycle with INITIALIZE=1 and EN=0, then go to FEED.
REQ-026 FEED SHALL last 1 cycle with EN=1, INITIALIZE=0 and STRING = buffer[index].
REQ-027 From FEED, the FSM SHALL go to FINISH if index == N-1; otherwise it SHALL increment index and go to GAP.
REQ-028 GAP SHALL last 1 cycle with INITIALIZE=1 and EN=0, then go to FEED.
REQ-029 FINISH SHALL last 1 cycle with DONE=1, EN=0 and INITIALIZE=0; it SHALL clear LEVEL and the write pointer to 0 and go to IDLE.
REQ-030 An unpaused stream of N bytes SHALL keep BUSY high for exactly 2N+1 cycles: 1 INIT + N FEED + (N-1) GAP + 1 FINISH.
REQ-031 The first EN cycle SHALL be the second cycle after the START edge.
REQ-032 PAUSE=1 in INIT, FEED or GAP SHALL freeze the state and index and force EN=0 and INITIALIZE=0.
REQ-033 While PAUSE=1, STRING SHALL hold its last value.
REQ-034 When PAUSE returns to 0, the frozen state SHALL execute in full.
REQ-035 PAUSE SHALL have no effect in IDLE or FINISH.
REQ-036 In IDLE, EN and INITIALIZE SHALL be 0 and STRING SHALL hold its last value.
REQ-037 LEVEL SHALL saturate at DEPTH and SHALL never wrap.
REQ-038 The write pointer SHALL wrap to 0 only through FINISH or reset.

Reset
REQ-039 When RST is asserted, the block SHALL immediately force the state to IDLE and EN=0, INITIALIZE=0, STRING=8'h00, LEVEL=0, FULL=0, BUSY=0, DONE=0, OVERFLOW=0, index=0 and write pointer=0.
REQ-040 Reset mid-stream SHALL abort the stream with no DONE pulse; buffer contents are don't-care.
REQ-041 After RST deasserts, the block SHALL accept writes on the first rising edge.

Verification
REQ-042 Write 8'h61, 8'h62, 8'h63, then START -> cycle sequence INIT, FEED 61, GAP, FEED 62, GAP, FEED 63, FINISH; BUSY high for 7 cycles; DONE pulses once; LEVEL returns to 0.
REQ-043 Write 32 bytes 8'h00..8'h1F, then a 33rd write -> FULL=1, OVERFLOW=1, LEVEL=32; after START, 32 EN cycles presenting 00..1F in order and OVERFLOW=0.
REQ-044 3-byte stream with PAUSE=1 for 4 cycles during the second FEED -> EN=0 and STRING=61 held during the pause, then FEED 62 resumes; BUSY high for 11 cycles total.
REQ-045 START with LEVEL=0 -> BUSY, EN and DONE all stay 0.
REQ-046 RST asserted mid-GAP of a 5-byte stream -> all outputs 0 immediately with no DONE; a new 1-byte write plus START then gives INIT, FEED, FINISH.
REQ-047 WR_EN=1 during BUSY -> LEVEL unchanged and OVERFLOW=0; START and WR_EN in the same IDLE cycle with LEVEL=2 -> 3 bytes streamed.
